alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational ALU datapath block.
- Accepts one operation per valid/ready handshake.
- Single-cycle ops complete in one cycle. Rotate is iterative, one bit position per cycle, under a small FSM.
- Result, carry and status are held in an output register until the downstream consumer accepts them. The register doubles as the accumulator for NOP.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_pipe_core.sv | 108 ++++++++++
 rtl/alu_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types for the alu_pipe datapath: opcode encodings, the rotate
// sequencer states and, when ALU_FLAGS_EN is defined, the status flag bundle.
// Optional feature macro: ALU_FLAGS_EN (adds zero/neg/ovf status flags).
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_PASSB = 4'd0,
      OP_PASSA = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_AND   = 4'd4,
      OP_INC   = 4'd5,
      OP_DEC   = 4'd6,
      OP_XOR   = 4'd7,
      OP_NOP   = 4'd8,
      OP_CLR   = 4'd9,
      OP_IOR   = 4'd10,
      OP_SWAPH = 4'd11,
      OP_COMP  = 4'd12,
      OP_CLRB  = 4'd13,
      OP_SETB  = 4'd14,
      OP_ROTL  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROT  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_e;

`ifdef ALU_FLAGS_EN
   typedef struct packed {
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;
`endif

endpackage

// File: rtl/alu_pipe_core.sv
// ----------------------------------------------------------------------------
// alu_pipe_core
// Purely combinational result logic for the single-cycle opcodes (0..14).
// NOP and ROTL are resolved in alu_pipe; here they just pass b through.
// Ports:
//   op          opcode
//   a, b        operands (W bits)
//   bit_number  bit index for CLRB/SETB
//   ans, c      result and carry/borrow
//   flags       zero/neg/ovf (only with ALU_FLAGS_EN)
// Optional feature macro: ALU_FLAGS_EN.
// ----------------------------------------------------------------------------
import alu_pkg::*;

module alu_pipe_core #(
   parameter int W  = 8,
   parameter int BW = $clog2(W)
) (
   input  alu_op_e        op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [BW-1:0]  bit_number,
   output logic [W-1:0]   ans,
`ifdef ALU_FLAGS_EN
   output alu_flags_t     flags,
`endif
   output logic           c
);

   // Two's-complement overflow of r = x + y.
   function automatic logic ovf_add(input logic signed [W-1:0] x,
                                    input logic signed [W-1:0] y,
                                    input logic signed [W-1:0] r);
      return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   // Two's-complement overflow of r = x - y.
   function automatic logic ovf_sub(input logic signed [W-1:0] x,
                                    input logic signed [W-1:0] y,
                                    input logic signed [W-1:0] r);
      return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   // Arithmetic is one bit wider so the top bit is the carry/borrow.
   logic [W:0] sum_add;
   logic [W:0] diff_sub;
   logic [W:0] sum_inc;
   logic [W:0] diff_dec;
   logic [W-1:0] bit_mask;
   logic signed [W-1:0] sa;
   logic signed [W-1:0] sb;
   logic signed [W-1:0] one_s;
   logic ovf;

   assign sum_add  = {1'b0, a} + {1'b0, b};
   assign diff_sub = {1'b0, b} - {1'b0, a};
   assign sum_inc  = {1'b0, b} + (W+1)'(1);
   assign diff_dec = {1'b0, b} - (W+1)'(1);
   assign bit_mask = {{(W-1){1'b0}}, 1'b1} << bit_number;
   assign sa       = signed'(a);
   assign sb       = signed'(b);
   assign one_s    = signed'(W'(1));

   always_comb begin
      ans = b;
      c   = 1'b0;
      ovf = 1'b0;
      case (op)
         OP_PASSB: ans = b;
         OP_PASSA: ans = a;
         OP_ADD: begin
            {c, ans} = sum_add;
            ovf      = ovf_add(sa, sb, signed'(sum_add[W-1:0]));
         end
         OP_SUB: begin
            {c, ans} = diff_sub;
            ovf      = ovf_sub(sb, sa, signed'(diff_sub[W-1:0]));
         end
         OP_AND:   ans = a & b;
         OP_INC: begin
            {c, ans} = sum_inc;
            ovf      = ovf_add(sb, one_s, signed'(sum_inc[W-1:0]));
         end
         OP_DEC: begin
            {c, ans} = diff_dec;
            ovf      = ovf_sub(sb, one_s, signed'(diff_dec[W-1:0]));
         end
         OP_XOR:   ans = a ^ b;
         OP_CLR:   ans = '0;
         OP_IOR:   ans = a | b;
         OP_SWAPH: ans = {b[W/2-1:0], b[W-1:W/2]};
         OP_COMP:  ans = ~b;
         OP_CLRB:  ans = b & ~bit_mask;
         OP_SETB:  ans = b | bit_mask;
         default:  ans = b;
      endcase
   end

`ifdef ALU_FLAGS_EN
   assign flags.zero = (ans == '0);
   assign flags.neg  = ans[W-1];
   assign flags.ovf  = ovf;
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// land in the output register on the accept edge; ROTL is iterated one bit
// per cycle by a small sequencer. The output register is also the NOP
// accumulator. W must be even and >= 4.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake
//   inst, a, b          opcode and operands (sampled on accept only)
//   bit_number          bit index for CLRB/SETB, rotate amount for ROTL
//   out_valid/out_ready result handshake
//   ansf, carry         result and carry registers
//   zero, neg, ovf      status flag registers (only with ALU_FLAGS_EN)
// Optional feature macro: ALU_FLAGS_EN.
// ----------------------------------------------------------------------------
import alu_pkg::*;

module alu_pipe #(
   parameter int W  = 8,
   parameter int BW = $clog2(W)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     inst,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [BW-1:0]  bit_number,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   ansf,
`ifdef ALU_FLAGS_EN
   output logic           zero,
   output logic           neg,
   output logic           ovf,
`endif
   output logic           carry
);

`ifdef ALU_FLAGS_EN
   // Flags for a value produced by the rotate path (never overflows).
   function automatic alu_flags_t plain_flags(input logic [W-1:0] v);
      plain_flags.zero = (v == '0);
      plain_flags.neg  = v[W-1];
      plain_flags.ovf  = 1'b0;
   endfunction
`endif

   alu_state_e    state;
   alu_op_e       op;
   logic [W-1:0]  core_ans;
   logic          core_c;

   // Output register stage
   logic [W-1:0]  ans_p1;
   logic          carry_p1;
   logic          vld_p1;

   // Rotate working stage
   logic [W-1:0]  rot_p0;
   logic          rot_c_p0;
   logic [BW-1:0] rot_cnt;

   logic          accept;
   logic          out_free;
   logic          is_rotl;
   logic          rot_start;
   logic          rot_last;
   logic [W-1:0]  rot_next;

   logic          load;
   logic          vld_set;
   logic [W-1:0]  ld_ans;
   logic          ld_c;

`ifdef ALU_FLAGS_EN
   alu_flags_t    core_flags;
   alu_flags_t    ld_flags;
   alu_flags_t    flags_p1;
`endif

   assign op        = alu_op_e'(inst);
   // The output register can take a new value when empty or being drained.
   assign out_free  = !vld_p1 || out_ready;
   assign in_ready  = (state == ST_IDLE) && out_free && !reset;
   assign accept    = in_valid && in_ready;
   assign is_rotl   = (op == OP_ROTL);
   assign rot_start = accept && is_rotl && (bit_number != '0);
   assign rot_last  = (rot_cnt == BW'(1));
   assign rot_next  = {rot_p0[W-2:0], rot_p0[W-1]};

   alu_pipe_core #(
      .W  (W),
      .BW (BW)
   ) u_core (
      .op         (op),
      .a          (a),
      .b          (b),
      .bit_number (bit_number),
      .ans        (core_ans),
`ifdef ALU_FLAGS_EN
      .flags      (core_flags),
`endif
      .c          (core_c)
   );

   // Select what, if anything, lands in the output register this cycle.
   always_comb begin
      load     = 1'b0;
      vld_set  = 1'b0;
      ld_ans   = core_ans;
      ld_c     = core_c;
`ifdef ALU_FLAGS_EN
      ld_flags = core_flags;
`endif
      case (state)
         ST_IDLE: begin
            if (accept && !rot_start) begin
               vld_set = 1'b1;
               // NOP re-presents the accumulator without touching it.
               load    = (op != OP_NOP);
               if (is_rotl) begin
                  ld_ans   = b;
                  ld_c     = 1'b0;
`ifdef ALU_FLAGS_EN
                  ld_flags = plain_flags(b);
`endif
               end
            end
         end
         ST_ROT: begin
            if (rot_last && out_free) begin
               load     = 1'b1;
               vld_set  = 1'b1;
               ld_ans   = rot_next;
               ld_c     = rot_p0[W-1];
`ifdef ALU_FLAGS_EN
               ld_flags = plain_flags(rot_next);
`endif
            end
         end
         ST_HOLD: begin
            if (out_free) begin
               load     = 1'b1;
               vld_set  = 1'b1;
               ld_ans   = rot_p0;
               ld_c     = rot_c_p0;
`ifdef ALU_FLAGS_EN
               ld_flags = plain_flags(rot_p0);
`endif
            end
         end
         default: ;
      endcase
   end

   // p0 -> p1: sequencer, rotate working register and output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         vld_p1   <= 1'b0;
         ans_p1   <= '0;
         carry_p1 <= 1'b0;
         rot_p0   <= '0;
         rot_c_p0 <= 1'b0;
         rot_cnt  <= '0;
`ifdef ALU_FLAGS_EN
         flags_p1 <= '0;
`endif
      end else begin
         if (vld_set)
            vld_p1 <= 1'b1;
         else if (out_ready)
            vld_p1 <= 1'b0;

         if (load) begin
            ans_p1   <= ld_ans;
            carry_p1 <= ld_c;
`ifdef ALU_FLAGS_EN
            flags_p1 <= ld_flags;
`endif
         end

         case (state)
            ST_IDLE: begin
               if (rot_start) begin
                  state   <= ST_ROT;
                  rot_p0  <= b;
                  rot_cnt <= bit_number;
               end
            end
            ST_ROT: begin
               rot_p0   <= rot_next;
               rot_c_p0 <= rot_p0[W-1];
               rot_cnt  <= rot_cnt - BW'(1);
               // A still-pending result parks the rotate output in HOLD.
               if (rot_last)
                  state <= out_free ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
               if (out_free)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ansf      = ans_p1;
   assign carry     = carry_p1;
   assign out_valid = vld_p1;
`ifdef ALU_FLAGS_EN
   assign zero      = flags_p1.zero;
   assign neg       = flags_p1.neg;
   assign ovf       = flags_p1.ovf;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Directed and randomised stimulus for alu_pipe (W=8). Expected results are
// produced by a reference model when an operation is accepted, queued, and
// compared when the result is consumed on the output handshake.
// ----------------------------------------------------------------------------
import alu_pkg::*;

module tb_alu_pipe;

   localparam int W  = 8;
   localparam int BW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    inst;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [BW-1:0] bit_number;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  ansf;
   logic          carry;
`ifdef ALU_FLAGS_EN
   logic          zero;
   logic          neg;
   logic          ovf;
`endif

   always #5 clk = ~clk;

   alu_pipe #(.W(W), .BW(BW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inst       (inst),
      .a          (a),
      .b          (b),
      .bit_number (bit_number),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ansf       (ansf),
`ifdef ALU_FLAGS_EN
      .zero       (zero),
      .neg        (neg),
      .ovf        (ovf),
`endif
      .carry      (carry)
   );

   typedef struct packed {
      logic [W-1:0] ans;
      logic         c;
      logic [2:0]   fl;   // {zero, neg, ovf}
   } exp_t;

   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  m_acc;
   logic          m_c;
   logic [2:0]    m_fl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model, written from the opcode table with integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] ma,
                                  input logic [W-1:0] mb, input logic [BW-1:0] bn);
      exp_t e;
      int   r;
      int   sa;
      int   sbv;
      logic v;
      sa  = int'($signed(ma));
      sbv = int'($signed(mb));
      e.ans = mb;
      e.c   = 1'b0;
      v     = 1'b0;
      case (op)
         4'd0:  e.ans = mb;
         4'd1:  e.ans = ma;
         4'd2: begin
            r = int'(ma) + int'(mb);
            e.ans = r[W-1:0];
            e.c   = r[W];
            v     = (sa + sbv > 127) || (sa + sbv < -128);
         end
         4'd3: begin
            e.ans = mb - ma;
            e.c   = (mb < ma);
            v     = (sbv - sa > 127) || (sbv - sa < -128);
         end
         4'd4:  e.ans = ma & mb;
         4'd5: begin
            e.ans = mb + 8'd1;
            e.c   = (mb == 8'hFF);
            v     = (sbv + 1 > 127);
         end
         4'd6: begin
            e.ans = mb - 8'd1;
            e.c   = (mb == 8'h00);
            v     = (sbv - 1 < -128);
         end
         4'd7:  e.ans = ma ^ mb;
         4'd8:  return {m_acc, m_c, m_fl};
         4'd9:  e.ans = '0;
         4'd10: e.ans = ma | mb;
         4'd11: e.ans = {mb[W/2-1:0], mb[W-1:W/2]};
         4'd12: e.ans = ~mb;
         4'd13: e.ans[bn] = 1'b0;
         4'd14: e.ans[bn] = 1'b1;
         default: begin
            // The bit rotated out of the MSB last ends up in the LSB.
            if (bn != '0) begin
               e.ans = (mb << bn) | (mb >> (W - int'(bn)));
               e.c   = e.ans[0];
            end
         end
      endcase
      e.fl = {(e.ans == '0), e.ans[W-1], v};
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the current request until accepted; returns 1 ns after the accept edge.
   task automatic wait_accept(input int budget);
      exp_t e;
      int   n;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
         if (n >= budget) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      e = model(inst, a, b, bit_number);
      sb.push_back(e);
      m_acc = e.ans;
      m_c   = e.c;
      m_fl  = e.fl;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [BW-1:0] ibn);
      inst       = op;
      a          = ia;
      b          = ib;
      bit_number = ibn;
      in_valid   = 1'b1;
      wait_accept(20);
   endtask

   // Scoreboard consumer: one compare per result taken on the output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_result", {31'd0, out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_ansf", {24'd0, ansf}, {24'd0, e.ans});
            chk("sb_carry", {31'd0, carry}, {31'd0, e.c});
`ifdef ALU_FLAGS_EN
            chk("sb_flags", {29'd0, zero, neg, ovf}, {29'd0, e.fl});
`endif
         end
      end
   end

   initial begin
      int k;
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      inst       = '0;
      a          = '0;
      b          = '0;
      bit_number = '0;
      m_acc      = '0;
      m_c        = 1'b0;
      m_fl       = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ansf", {24'd0, ansf}, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      step();

      // ADD with carry, one-cycle latency
      issue(OP_ADD, 8'hF0, 8'h20, 0);
      @(negedge clk);
      chk("add_out_valid", {31'd0, out_valid}, 32'd1);
      chk("add_ansf", {24'd0, ansf}, 32'h10);
      chk("add_carry", {31'd0, carry}, 32'd1);
      step();

      // SUB b-a with borrow
      issue(OP_SUB, 8'd5, 8'd3, 0);
      @(negedge clk);
      chk("sub_ansf", {24'd0, ansf}, 32'hFE);
      chk("sub_borrow", {31'd0, carry}, 32'd1);
      step();

      // Back-to-back INC FF / DEC 00, then NOP re-reads the accumulator
      issue(OP_INC, 8'h00, 8'hFF, 0);
      issue(OP_DEC, 8'h00, 8'h00, 0);
      @(negedge clk);
      chk("dec_ansf", {24'd0, ansf}, 32'hFF);
      chk("dec_carry", {31'd0, carry}, 32'd1);
      step();
      issue(OP_NOP, 8'h55, 8'h66, 0);
      @(negedge clk);
      chk("nop_out_valid", {31'd0, out_valid}, 32'd1);
      chk("nop_ansf", {24'd0, ansf}, 32'hFF);
      step();
      @(negedge clk);
      chk("nop_pulse_drop", {31'd0, out_valid}, 32'd0);
      step();

      // Output stall: result held while a new request waits
      out_ready = 1'b0;
      issue(OP_ADD, 8'd1, 8'd2, 0);
      inst     = OP_XOR;
      a        = 8'hAA;
      b        = 8'h55;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ansf", {24'd0, ansf}, 32'd3);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         a = a + 8'd1;
         #1;
         a = 8'hAA;
      end
      step();
      out_ready = 1'b1;
      wait_accept(5);
      @(negedge clk);
      chk("stall_next_ansf", {24'd0, ansf}, 32'hFF);
      step();

      // ROTL by 3: busy for the rotate, result after 4 cycles
      issue(OP_ROTL, 8'h00, 8'b1000_0001, 3'd3);
      k = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         k = i;
         if (out_valid === 1'b1) break;
         chk("rot_in_ready", {31'd0, in_ready}, 32'd0);
      end
      chk("rot_latency", k, 32'd4);
      chk("rot_ansf", {24'd0, ansf}, 32'b0000_1100);
      chk("rot_carry", {31'd0, carry}, 32'd0);
      step();

      // ROTL by 2 with the consumer stalled at completion
      issue(OP_ROTL, 8'h00, 8'b1100_0011, 3'd2);
      out_ready = 1'b0;
      k = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         k = i;
         if (out_valid === 1'b1) break;
      end
      chk("rot2_latency", k, 32'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rot2_hold_ansf", {24'd0, ansf}, 32'h0F);
         chk("rot2_hold_carry", {31'd0, carry}, 32'd1);
         chk("rot2_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      step();
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("rot2_drained", {31'd0, out_valid}, 32'd0);
      step();

`ifdef ALU_FLAGS_EN
      // Status flags
      issue(OP_SETB, 8'h00, 8'h00, 3'd7);
      @(negedge clk);
      chk("setb_ansf", {24'd0, ansf}, 32'h80);
      chk("setb_neg", {31'd0, neg}, 32'd1);
      chk("setb_zero", {31'd0, zero}, 32'd0);
      step();
      issue(OP_ADD, 8'h7F, 8'h01, 0);
      @(negedge clk);
      chk("add_ovf", {31'd0, ovf}, 32'd1);
      step();
      issue(OP_CLRB, 8'h00, 8'h01, 3'd0);
      @(negedge clk);
      chk("clrb_zero", {31'd0, zero}, 32'd1);
      step();
`endif

      // Remaining opcodes, including ROTL by 0
      issue(OP_AND,   8'hCC, 8'hAA, 0);
      issue(OP_IOR,   8'hCC, 8'hAA, 0);
      issue(OP_SWAPH, 8'h00, 8'h3C, 0);
      issue(OP_COMP,  8'h00, 8'h3C, 0);
      issue(OP_CLRB,  8'h00, 8'hFF, 3'd4);
      issue(OP_SETB,  8'h00, 8'h00, 3'd6);
      issue(OP_CLR,   8'h12, 8'h34, 0);
      issue(OP_PASSA, 8'h9A, 8'h34, 0);
      issue(OP_PASSB, 8'h9A, 8'h34, 0);
      issue(OP_ROTL,  8'h00, 8'h81, 3'd0);
      issue(OP_ROTL,  8'h00, 8'h81, 3'd7);

      // Random mix
      for (int i = 0; i < 40; i++)
         issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      step();

      // Reset in the middle of a rotate abandons it
      issue(OP_PASSA, 8'h5A, 8'h00, 0);
      issue(OP_ROTL, 8'h00, 8'hF0, 3'd6);
      step();
      step();
      reset = 1'b1;
      #1;
      chk("mid_rst_ansf", {24'd0, ansf}, 32'd0);
      chk("mid_rst_carry", {31'd0, carry}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      sb.delete();
      m_acc = '0;
      m_c   = 1'b0;
      m_fl  = '0;
      @(negedge clk);
      chk("mid_rst_in_ready_held", {31'd0, in_ready}, 32'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_release_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (8) @(negedge clk);
      chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
      step();
      issue(OP_NOP, 8'h11, 8'h22, 0);
      @(negedge clk);
      chk("post_rst_nop_ansf", {24'd0, ansf}, 32'd0);
      step();

      repeat (3) step();
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute safety net against a stuck run.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
